// File: rtl/btn_pkg.sv
// Shared constants for the push-button debouncer: board defaults and FSM state encodings.
// Auto-repeat defaults exist only when BTN_AUTOREPEAT_EN is defined.
package btn_pkg;

   localparam int unsigned DEF_NBTN         = 5;
   localparam int unsigned DEF_STABLE_TICKS = 2;
`ifdef BTN_AUTOREPEAT_EN
   localparam int unsigned DEF_REPEAT_DELAY = 50;
   localparam int unsigned DEF_REPEAT_RATE  = 10;
`endif

   localparam logic [1:0] ST_REL      = 2'd0;
   localparam logic [1:0] ST_REL_PEND = 2'd1;
   localparam logic [1:0] ST_PRS      = 2'd2;
   localparam logic [1:0] ST_PRS_PEND = 2'd3;

endpackage

// File: rtl/btn_debounce_cell.sv
// One button: raw-pin synchronizer, tick-qualified debounce FSM and registered level/pulses.
// BTN_AUTOREPEAT_EN adds a hold counter that re-emits press pulses while the button is held.
module btn_debounce_cell
   import btn_pkg::*;
#(
   parameter int unsigned STABLE_TICKS = DEF_STABLE_TICKS
`ifdef BTN_AUTOREPEAT_EN
  ,parameter int unsigned REPEAT_DELAY = DEF_REPEAT_DELAY
  ,parameter int unsigned REPEAT_RATE  = DEF_REPEAT_RATE
`endif
) (
   input  logic clk,
   input  logic rst,
   input  logic tick_i,
   input  logic raw_i,
   output logic level_o,
   output logic press_o,
   output logic release_o
);

   localparam int unsigned CW = $clog2(STABLE_TICKS + 1);

   logic [1:0]    sync_q;
   logic [1:0]    state_q, state_d;
   logic [CW-1:0] cnt_q, cnt_d, cnt_inc;
   logic          level_q, level_d;
   logic          press_q, press_d, release_q, release_d;
   logic          press_pulse;
   logic          sample;

   assign sample  = sync_q[1];
   assign cnt_inc = (cnt_q == CW'(STABLE_TICKS)) ? cnt_q : cnt_q + CW'(1);

   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      level_d   = level_q;
      press_d   = 1'b0;
      release_d = 1'b0;
      if (tick_i) begin
         case (state_q)
            ST_REL: begin
               if (sample) begin
                  if (STABLE_TICKS == 1) begin
                     state_d = ST_PRS;
                     level_d = 1'b1;
                     press_d = 1'b1;
                  end else begin
                     state_d = ST_REL_PEND;
                     cnt_d   = CW'(1);
                  end
               end
            end
            ST_REL_PEND: begin
               if (!sample) begin
                  state_d = ST_REL;
                  cnt_d   = '0;
               end else if (cnt_inc == CW'(STABLE_TICKS)) begin
                  state_d = ST_PRS;
                  cnt_d   = '0;
                  level_d = 1'b1;
                  press_d = 1'b1;
               end else begin
                  cnt_d = cnt_inc;
               end
            end
            ST_PRS: begin
               if (!sample) begin
                  if (STABLE_TICKS == 1) begin
                     state_d   = ST_REL;
                     level_d   = 1'b0;
                     release_d = 1'b1;
                  end else begin
                     state_d = ST_PRS_PEND;
                     cnt_d   = CW'(1);
                  end
               end
            end
            ST_PRS_PEND: begin
               if (sample) begin
                  state_d = ST_PRS;
                  cnt_d   = '0;
               end else if (cnt_inc == CW'(STABLE_TICKS)) begin
                  state_d   = ST_REL;
                  cnt_d     = '0;
                  level_d   = 1'b0;
                  release_d = 1'b1;
               end else begin
                  cnt_d = cnt_inc;
               end
            end
            default: begin
               state_d = ST_REL;
               cnt_d   = '0;
               level_d = 1'b0;
            end
         endcase
      end
   end

`ifdef BTN_AUTOREPEAT_EN
   localparam int unsigned HW = $clog2(REPEAT_DELAY + REPEAT_RATE + 1);

   logic [HW-1:0] hold_q, hold_d, hold_inc;
   logic          rpt_d;

   assign hold_inc = hold_q + HW'(1);

   // Hold count freezes in PRS_PEND; after the first repeat it cycles between DELAY and DELAY+RATE.
   always_comb begin
      hold_d = hold_q;
      rpt_d  = 1'b0;
      if (!level_d) begin
         hold_d = '0;
      end else if (tick_i && (state_q == ST_PRS) && (state_d == ST_PRS)) begin
         hold_d = hold_inc;
         if (hold_inc == HW'(REPEAT_DELAY)) begin
            rpt_d = 1'b1;
         end else if (hold_inc == HW'(REPEAT_DELAY + REPEAT_RATE)) begin
            rpt_d  = 1'b1;
            hold_d = HW'(REPEAT_DELAY);
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) hold_q <= '0;
      else     hold_q <= hold_d;
   end

   assign press_pulse = press_d | rpt_d;
`else
   assign press_pulse = press_d;
`endif

   always_ff @(posedge clk) begin
      if (rst) begin
         sync_q    <= 2'b00;
         state_q   <= ST_REL;
         cnt_q     <= '0;
         level_q   <= 1'b0;
         press_q   <= 1'b0;
         release_q <= 1'b0;
      end else begin
         sync_q    <= {sync_q[0], raw_i};
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         level_q   <= level_d;
         press_q   <= press_pulse;
         release_q <= release_d;
      end
   end

   assign level_o   = level_q;
   assign press_o   = press_q;
   assign release_o = release_q;

endmodule

// File: rtl/btn_debounce.sv
// Debounces NBTN push-buttons using a synchronized 100 Hz slow clock as the sampling strobe.
// Define BTN_AUTOREPEAT_EN to enable press auto-repeat while a button is held.
module btn_debounce
   import btn_pkg::*;
#(
   parameter int unsigned NBTN         = DEF_NBTN,
   parameter int unsigned STABLE_TICKS = DEF_STABLE_TICKS
`ifdef BTN_AUTOREPEAT_EN
  ,parameter int unsigned REPEAT_DELAY = DEF_REPEAT_DELAY
  ,parameter int unsigned REPEAT_RATE  = DEF_REPEAT_RATE
`endif
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            slow_clk,
   input  logic [NBTN-1:0] btn_raw,
   output logic [NBTN-1:0] btn_level,
   output logic [NBTN-1:0] btn_press,
   output logic [NBTN-1:0] btn_release
);

   logic slow_s1_q, slow_s2_q, slow_prev_q, tick_q;

   // Sync flops reset high so a slow_clk already high at reset does not produce a tick.
   always_ff @(posedge clk) begin
      if (rst) begin
         slow_s1_q   <= 1'b1;
         slow_s2_q   <= 1'b1;
         slow_prev_q <= 1'b1;
         tick_q      <= 1'b0;
      end else begin
         slow_s1_q   <= slow_clk;
         slow_s2_q   <= slow_s1_q;
         slow_prev_q <= slow_s2_q;
         tick_q      <= slow_s2_q & ~slow_prev_q;
      end
   end

   for (genvar i = 0; i < NBTN; i++) begin : gen_cell
      btn_debounce_cell #(
         .STABLE_TICKS (STABLE_TICKS)
`ifdef BTN_AUTOREPEAT_EN
        ,.REPEAT_DELAY (REPEAT_DELAY)
        ,.REPEAT_RATE  (REPEAT_RATE)
`endif
      ) u_cell (
         .clk       (clk),
         .rst       (rst),
         .tick_i    (tick_q),
         .raw_i     (btn_raw[i]),
         .level_o   (btn_level[i]),
         .press_o   (btn_press[i]),
         .release_o (btn_release[i])
      );
   end

endmodule

// File: tb/tb_btn_debounce.sv
// Directed bench for btn_debounce with a 20-cycle slow_clk; covers auto-repeat when BTN_AUTOREPEAT_EN is set.
module tb_btn_debounce;
   import btn_pkg::*;

   localparam int unsigned NB = 5;

   logic          clk      = 1'b0;
   logic          rst      = 1'b1;
   logic          slow_clk = 1'b1;
   logic          slow_en  = 1'b0;
   logic [NB-1:0] btn_raw  = '0;
   logic [NB-1:0] btn_level, btn_press, btn_release;

   int n_checks = 0;
   int n_fail   = 0;
   int press_cnt [NB];
   int rel_cnt   [NB];
   int overlap   = 0;

   btn_debounce #(
      .NBTN         (NB),
      .STABLE_TICKS (2)
`ifdef BTN_AUTOREPEAT_EN
     ,.REPEAT_DELAY (4)
     ,.REPEAT_RATE  (2)
`endif
   ) dut (
      .clk         (clk),
      .rst         (rst),
      .slow_clk    (slow_clk),
      .btn_raw     (btn_raw),
      .btn_level   (btn_level),
      .btn_press   (btn_press),
      .btn_release (btn_release)
   );

   always #5 clk = ~clk;

   always begin
      if (slow_en) begin
         repeat (10) @(posedge clk);
         #2 slow_clk = ~slow_clk;
      end else begin
         @(posedge clk);
      end
   end

   always @(negedge clk) begin
      for (int i = 0; i < int'(NB); i++) begin
         press_cnt[i] += int'(btn_press[i]);
         rel_cnt[i]   += int'(btn_release[i]);
      end
      if ((btn_press & btn_release) != '0) overlap++;
   end

   task automatic clear_counts();
      @(negedge clk);
      #1;
      for (int i = 0; i < int'(NB); i++) begin
         press_cnt[i] = 0;
         rel_cnt[i]   = 0;
      end
   endtask

   // Returns at the negedge where tick is visible; the cell consumes it at the next posedge.
   task automatic wait_tick();
      int n = 0;
      @(negedge clk);
      while (dut.tick_q !== 1'b1 && n < 100) begin
         @(negedge clk);
         n++;
      end
      if (n >= 100) begin
         n_checks++;
         n_fail++;
         $display("FAIL tick_timeout: no tick within %0d cycles, required one", n);
      end
   endtask

   task automatic test_reset();
      int ticks = 0;
      int bad   = 0;
      int n     = 0;
      rst     = 1'b1;
      btn_raw = '0;
      repeat (4) begin
         @(negedge clk);
         if (dut.tick_q) ticks++;
         if ((btn_level | btn_press | btn_release) != '0) bad++;
      end
      rst = 1'b0;
      repeat (30) begin
         @(negedge clk);
         if (dut.tick_q) ticks++;
         if ((btn_level | btn_press | btn_release) != '0) bad++;
      end
      n_checks++;
      if (ticks !== 0) begin n_fail++; $display("FAIL reset_no_tick: got %0d ticks, required 0", ticks); end
      n_checks++;
      if (bad !== 0) begin n_fail++; $display("FAIL reset_outputs_zero: got %0d nonzero cycles, required 0", bad); end
      slow_en = 1'b1;
      while (slow_clk !== 1'b0 && n < 100) begin @(negedge clk); n++; end
      while (slow_clk !== 1'b1 && n < 100) begin @(negedge clk); n++; end
      n = 0;
      @(negedge clk);
      n = 1;
      while (dut.tick_q !== 1'b1 && n < 20) begin @(negedge clk); n++; end
      n_checks++;
      if (n !== 3) begin n_fail++; $display("FAIL tick_latency: got %0d cycles, required 3", n); end
   endtask

   task automatic test_single_press();
      clear_counts();
      wait_tick();
      btn_raw[0] = 1'b1;
      wait_tick();
      @(negedge clk);
      n_checks++;
      if (btn_level[0] !== 1'b0 || btn_press !== '0) begin
         n_fail++; $display("FAIL press0_early: level %b press %b, required 0 and 00000", btn_level[0], btn_press);
      end
      wait_tick();
      n_checks++;
      if (btn_level[0] !== 1'b0) begin n_fail++; $display("FAIL press0_level_pre: got %b, required 0", btn_level[0]); end
      @(negedge clk);
      n_checks++;
      if (btn_press !== 5'b00001) begin n_fail++; $display("FAIL press0_pulse: got %b, required 00001", btn_press); end
      n_checks++;
      if (btn_level !== 5'b00001) begin n_fail++; $display("FAIL press0_level: got %b, required 00001", btn_level); end
      @(negedge clk);
      n_checks++;
      if (btn_press !== 5'b00000) begin n_fail++; $display("FAIL press0_one_cycle: got %b, required 00000", btn_press); end
      repeat (3) wait_tick();
      btn_raw[0] = 1'b0;
      #1;
      n_checks++;
      if (press_cnt[0] !== 1) begin n_fail++; $display("FAIL press0_count: got %0d, required 1", press_cnt[0]); end
      wait_tick();
      wait_tick();
      @(negedge clk);
      n_checks++;
      if (btn_release !== 5'b00001 || btn_level !== 5'b00000) begin
         n_fail++; $display("FAIL release0: release %b level %b, required 00001 and 00000", btn_release, btn_level);
      end
   endtask

   task automatic test_bounce();
      clear_counts();
      wait_tick();
      btn_raw[2] = 1'b1;
      wait_tick();
      btn_raw[2] = 1'b0;
      @(negedge clk);
      n_checks++;
      if (dut.gen_cell[2].u_cell.state_q !== ST_REL_PEND) begin
         n_fail++; $display("FAIL bounce_pend: state %0d, required %0d", dut.gen_cell[2].u_cell.state_q, ST_REL_PEND);
      end
      wait_tick();
      @(negedge clk);
      n_checks++;
      if (dut.gen_cell[2].u_cell.state_q !== ST_REL) begin
         n_fail++; $display("FAIL bounce_back_rel: state %0d, required %0d", dut.gen_cell[2].u_cell.state_q, ST_REL);
      end
      repeat (2) wait_tick();
      #1;
      n_checks++;
      if (press_cnt[2] !== 0 || btn_level[2] !== 1'b0) begin
         n_fail++; $display("FAIL bounce_no_pulse: presses %0d level %b, required 0 and 0", press_cnt[2], btn_level[2]);
      end
   endtask

   task automatic test_simultaneous();
      clear_counts();
      wait_tick();
      btn_raw[1] = 1'b1;
      btn_raw[4] = 1'b1;
      wait_tick();
      wait_tick();
      @(negedge clk);
      n_checks++;
      if (btn_press !== 5'b10010) begin n_fail++; $display("FAIL simul_press: got %b, required 10010", btn_press); end
      n_checks++;
      if (btn_level !== 5'b10010) begin n_fail++; $display("FAIL simul_level: got %b, required 10010", btn_level); end
      btn_raw[1] = 1'b0;
      btn_raw[4] = 1'b0;
      wait_tick();
      wait_tick();
      @(negedge clk);
      n_checks++;
      if (btn_release !== 5'b10010 || btn_press !== 5'b00000) begin
         n_fail++; $display("FAIL simul_release: release %b press %b, required 10010 and 00000", btn_release, btn_press);
      end
      #1;
      n_checks++;
      if (rel_cnt[1] !== 1 || rel_cnt[4] !== 1) begin
         n_fail++; $display("FAIL simul_rel_count: got %0d/%0d, required 1/1", rel_cnt[1], rel_cnt[4]);
      end
   endtask

   task automatic test_reset_mid();
      clear_counts();
      wait_tick();
      btn_raw[3] = 1'b1;
      wait_tick();
      @(negedge clk);
      n_checks++;
      if (dut.gen_cell[3].u_cell.state_q !== ST_REL_PEND) begin
         n_fail++; $display("FAIL rstmid_pend: state %0d, required %0d", dut.gen_cell[3].u_cell.state_q, ST_REL_PEND);
      end
      rst = 1'b1;
      repeat (2) @(negedge clk);
      rst = 1'b0;
      n_checks++;
      if (dut.gen_cell[3].u_cell.state_q !== ST_REL || btn_level !== 5'b00000) begin
         n_fail++; $display("FAIL rstmid_cleared: state %0d level %b, required %0d and 00000",
                            dut.gen_cell[3].u_cell.state_q, btn_level, ST_REL);
      end
      wait_tick();
      @(negedge clk);
      n_checks++;
      if (btn_level[3] !== 1'b0 || btn_press !== '0) begin
         n_fail++; $display("FAIL rstmid_early: level %b press %b, required 0 and 00000", btn_level[3], btn_press);
      end
      wait_tick();
      @(negedge clk);
      n_checks++;
      if (btn_press !== 5'b01000 || btn_level !== 5'b01000) begin
         n_fail++; $display("FAIL rstmid_press: press %b level %b, required 01000 and 01000", btn_press, btn_level);
      end
      #1;
      n_checks++;
      if (press_cnt[3] !== 1) begin n_fail++; $display("FAIL rstmid_count: got %0d, required 1", press_cnt[3]); end
      btn_raw[3] = 1'b0;
      wait_tick();
      wait_tick();
      @(negedge clk);
      n_checks++;
      if (btn_release !== 5'b01000) begin n_fail++; $display("FAIL rstmid_release: got %b, required 01000", btn_release); end
   endtask

`ifdef BTN_AUTOREPEAT_EN
   task automatic test_autorepeat();
      logic exp;
      clear_counts();
      wait_tick();
      btn_raw[0] = 1'b1;
      wait_tick();
      wait_tick();
      @(negedge clk);
      n_checks++;
      if (btn_press !== 5'b00001) begin n_fail++; $display("FAIL rpt_initial: got %b, required 00001", btn_press); end
      for (int k = 1; k <= 10; k++) begin
         wait_tick();
         @(negedge clk);
         exp = (k >= 4) && (k % 2 == 0);
         n_checks++;
         if (btn_press[0] !== exp) begin
            n_fail++; $display("FAIL rpt_hold_tick_%0d: got %b, required %b", k, btn_press[0], exp);
         end
      end
      btn_raw[0] = 1'b0;
      wait_tick();
      wait_tick();
      @(negedge clk);
      #1;
      n_checks++;
      if (press_cnt[0] !== 5 || rel_cnt[0] !== 1) begin
         n_fail++; $display("FAIL rpt_totals: presses %0d releases %0d, required 5 and 1", press_cnt[0], rel_cnt[0]);
      end
   endtask
`else
   task automatic test_hold_no_repeat();
      clear_counts();
      wait_tick();
      btn_raw[0] = 1'b1;
      repeat (12) wait_tick();
      btn_raw[0] = 1'b0;
      wait_tick();
      wait_tick();
      @(negedge clk);
      #1;
      n_checks++;
      if (press_cnt[0] !== 1 || rel_cnt[0] !== 1) begin
         n_fail++; $display("FAIL hold_no_repeat: presses %0d releases %0d, required 1 and 1", press_cnt[0], rel_cnt[0]);
      end
   endtask
`endif

   initial begin
      for (int i = 0; i < int'(NB); i++) begin
         press_cnt[i] = 0;
         rel_cnt[i]   = 0;
      end
      test_reset();
      test_single_press();
      test_bounce();
      test_simultaneous();
      test_reset_mid();
`ifdef BTN_AUTOREPEAT_EN
      test_autorepeat();
`else
      test_hold_no_repeat();
`endif
      n_checks++;
      if (overlap !== 0) begin n_fail++; $display("FAIL press_release_overlap: got %0d cycles, required 0", overlap); end
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/btn_debounce.md
# btn_debounce

Consumes the 100 Hz slowed clock produced for the ATM front panel and uses it as a sampling strobe to debounce the Basys-3 push-buttons. It emits clean levels plus single-cycle press/release pulses in the 100 MHz domain. It sits between the raw board pins and the ATM menu/keypad FSM, which reacts only to `btn_press` pulses.

## Interface
- `NBTN`, 5, number of buttons debounced (Basys-3 U/D/L/R/C)
- `STABLE_TICKS`, 2, consecutive differing 100 Hz samples needed to accept a change (≥1; 2 = 20 ms)
- `REPEAT_DELAY`, 50, ticks held before first auto-repeat (only with `BTN_AUTOREPEAT_EN`)
- `REPEAT_RATE`, 10, ticks between subsequent auto-repeats (only with `BTN_AUTOREPEAT_EN`)
- `clk` in 1: 100 MHz board clock; all logic is on its rising edge
- `rst` in 1: synchronous, active-high reset
- `slow_clk` in 1: 100 Hz slowed clock, treated as asynchronous data, not as a clock
- `btn_raw` in NBTN: raw, bouncing button pins, active-high
- `btn_level` out NBTN: debounced level per button
- `btn_press` out NBTN: 1-cycle pulse on an accepted 0→1 change (and on auto-repeat)
- `btn_release` out NBTN: 1-cycle pulse on an accepted 1→0 change

## Operation
- Front end: 2-flop synchronizer on each `btn_raw` bit and on `slow_clk`; a third flop holds previous synced `slow_clk`. `tick` = synced & ~prev, one `clk` cycle wide per 100 Hz period.
- Per-button FSM, evaluated only on `tick`; between ticks, state and counters hold.
  - REL (level 0): sample=1 → REL_PEND, cnt=1; if STABLE_TICKS=1, go directly to PRS and pulse.
  - REL_PEND: sample=1 → cnt+1; at cnt==STABLE_TICKS → PRS, level←1, press pulse. sample=0 → REL, cnt=0 (bounce rejected, no pulse).
  - PRS (level 1): sample=0 → PRS_PEND, cnt=1, same rule.
  - PRS_PEND: sample=0 → cnt+1; at cnt==STABLE_TICKS → REL, level←0, release pulse. sample=1 → PRS, cnt=0.
- Counter width $clog2(STABLE_TICKS+1); saturates, never wraps.
- Buttons are fully independent; simultaneous changes give simultaneous pulses on separate bits.
- Press and release pulses for one button are never asserted in the same cycle.

## Timing
- Reset values: `btn_level`=0, `btn_press`=0, `btn_release`=0, all FSMs REL, counters 0, button sync flops 0, `slow_clk` sync and prev flops 1. No spurious tick after reset if `slow_clk` is already high; the first tick requires a genuine 0→1 edge.
- `tick` asserts 3 `clk` cycles after a `slow_clk` rising edge (2 sync + edge register).
- Pulses and the level change are registered and appear the cycle after the qualifying `tick`.
- Minimum accepted change latency: STABLE_TICKS ticks after the first differing sample.
- Reset mid-debounce: pending counts are discarded, no pulse is emitted, and level is 0 even if the button is held. A held button is re-accepted after STABLE_TICKS ticks as a fresh press.

## Configuration
- `BTN_AUTOREPEAT_EN` defined: in PRS, a per-button hold counter counts ticks. At REPEAT_DELAY it emits an extra `btn_press` pulse, then one every REPEAT_RATE ticks while held. The counter clears on leaving PRS. The PRS_PEND transient does not clear it, but no repeat pulse is emitted while in PRS_PEND.
- Undefined: exactly one `btn_press` per accepted press. The hold counter and the two repeat parameters are unused and not synthesized.

## Structure
- Package `btn_pkg`: state enum (REL, REL_PEND, PRS, PRS_PEND), default constants (board 5 buttons, 2 stable ticks, repeat defaults).
- Sub-module `btn_debounce_cell`: one button's synchronizer, FSM, counters and optional repeat logic; takes `clk`, `rst`, `tick`, raw bit. The top instantiates NBTN cells with a generate loop and owns the shared `slow_clk` synchronizer and edge detector.

## Test plan
Bench drives `slow_clk` with a 20-cycle period for speed; STABLE_TICKS=2 unless noted.
- Reset with `slow_clk`=1 held → no `tick` until the next 0→1 edge; all outputs 0 throughout.
- `btn_raw[0]` 0→1 and held → exactly one `btn_press[0]` pulse, 1 cycle after the 2nd tick; `btn_level[0]`=1 from the same cycle.
- `btn_raw[2]` high for 1 tick, then low → no pulse, level stays 0, cell returns to REL.
- Buttons 1 and 4 rise in the same cycle and are held → `btn_press`=5'b10010 in a single cycle; release both → `btn_release`=5'b10010 together.
- `rst` pulse while button 3 is in REL_PEND → no pulse; hold continues → press accepted 2 ticks after reset deasserts.
- With `BTN_AUTOREPEAT_EN`, REPEAT_DELAY=4, REPEAT_RATE=2, hold 10 ticks after acceptance → press pulses at hold ticks 4, 6, 8, 10 in addition to the initial press.
